// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle RV32I control FSM: opcodes, mux encodings,
// state encoding, trap causes and the per-state control word.
package multicycle_control_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS1   = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    LOAD_WB   = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE   = 4'd6,
    ALU_WB    = 4'd7,
    BRANCH    = 4'd8,
    TRAP      = 4'd9
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       pc_write_cond;
    logic       pc_source;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       mem_to_reg;
    logic       reg_write;
    logic       trap;
  } ctl_t;

  // Moore control word for a state; the FETCH completion extras depend on mem_ready
  // and are added in the top.
  function automatic ctl_t state_ctl(state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH: c.mem_req = 1'b1;
      DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      MEM_ADDR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      MEM_READ: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      LOAD_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      MEM_WRITE: begin
        c.mem_req = 1'b1;
        c.mem_we  = 1'b1;
        c.iord    = 1'b1;
      end
      EXECUTE: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_RS2;
        c.alu_op    = ALU_FUNCT;
      end
      ALU_WB: c.reg_write = 1'b1;
      BRANCH: begin
        c.alu_src_a     = SRCA_RS1;
        c.alu_src_b     = SRCB_RS2;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 1'b1;
      end
      TRAP: c.trap = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_opcode_classify.sv
// Combinational opcode classifier for the supported RV32I subset.
module opcode_classify
  import multicycle_control_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       is_r,
  output logic       is_load,
  output logic       is_store,
  output logic       is_beq,
  output logic       is_illegal
);

  assign is_r       = (opcode == OP_R);
  assign is_load    = (opcode == OP_LOAD);
  assign is_store   = (opcode == OP_STORE);
  assign is_beq     = (opcode == OP_BEQ);
  assign is_illegal = !(is_r || is_load || is_store || is_beq);

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a shared-memory multicycle RV32I datapath, with illegal-opcode
// and memory-wait-timeout traps.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 16,
  parameter int WAIT_W       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_source,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic [3:0] state,
  output logic       trap,
  output logic [1:0] trap_cause
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

  state_t            state_q, state_d;
  ctl_t              ctl_q, ctl;
  logic [1:0]        cause_q, cause_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout;
  logic              is_r, is_load, is_store, is_beq, is_illegal;

  opcode_classify u_classify (
    .opcode     (opcode),
    .is_r       (is_r),
    .is_load    (is_load),
    .is_store   (is_store),
    .is_beq     (is_beq),
    .is_illegal (is_illegal)
  );

  assign timeout = (MEM_WAIT_MAX != 0) && ctl_q.mem_req && !mem_ready && (wait_cnt == WAIT_LAST);

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      FETCH: begin
        if (mem_ready) state_d = DECODE;
        else if (timeout) begin
          state_d = TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      DECODE: begin
        if (is_illegal) begin
          state_d = TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
        else if (is_r) state_d = EXECUTE;
        else if (is_beq) state_d = BRANCH;
        else state_d = MEM_ADDR;
      end
      // A non-memory opcode appearing here is treated as illegal rather than guessed at.
      MEM_ADDR: begin
        if (is_load) state_d = MEM_READ;
        else if (is_store) state_d = MEM_WRITE;
        else begin
          state_d = TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      MEM_READ: begin
        if (mem_ready) state_d = LOAD_WB;
        else if (timeout) begin
          state_d = TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      MEM_WRITE: begin
        if (mem_ready) state_d = FETCH;
        else if (timeout) begin
          state_d = TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      LOAD_WB: state_d = FETCH;
      EXECUTE: state_d = ALU_WB;
      ALU_WB:  state_d = FETCH;
      BRANCH:  state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  // Control word is registered from the next state so outputs come straight off flops;
  // the wait counter saturates and clears whenever the access completes or is abandoned.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      ctl_q    <= state_ctl(FETCH);
      cause_q  <= CAUSE_NONE;
      wait_cnt <= '0;
    end
    else begin
      state_q <= state_d;
      ctl_q   <= state_ctl(state_d);
      cause_q <= cause_d;
      if (ctl_q.mem_req && !mem_ready && (state_d == state_q)) begin
        if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
      end
      else wait_cnt <= '0;
    end
  end

  always_comb begin
    ctl      = ctl_q;
    ir_write = 1'b0;
    pc_write = 1'b0;
    if (state_q == FETCH && mem_ready) begin
      ir_write      = 1'b1;
      pc_write      = 1'b1;
      ctl.alu_src_b = SRCB_FOUR;
    end
    if (rst) begin
      ctl      = '0;
      ir_write = 1'b0;
      pc_write = 1'b0;
    end
  end

  assign mem_req       = ctl.mem_req;
  assign mem_we        = ctl.mem_we;
  assign iord          = ctl.iord;
  assign pc_write_cond = ctl.pc_write_cond;
  assign pc_source     = ctl.pc_source;
  assign alu_src_a     = ctl.alu_src_a;
  assign alu_src_b     = ctl.alu_src_b;
  assign alu_op        = ctl.alu_op;
  assign mem_to_reg    = ctl.mem_to_reg;
  assign reg_write     = ctl.reg_write;
  assign trap          = ctl.trap;
  assign state         = state_q;
  assign trap_cause    = cause_q;

endmodule
